// File: rtl/cache_pkg.sv
// Shared constants and FSM state encoding for the direct-mapped cache fill controller.
package cache_pkg;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int INDEX_W = 4;
    localparam int TAG_W   = ADDR_W - INDEX_W;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MEM_RD = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_MEM_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;
endpackage

// File: rtl/cache_valid_bits.sv
// Per-line valid flags: cleared by reset, set on any cache write, read combinationally by index.
module cache_valid_bits #(
    parameter int INDEX_W = cache_pkg::INDEX_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               set,
    input  logic [INDEX_W-1:0] set_idx,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid
);
    logic [(2**INDEX_W)-1:0] valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (set) begin
            valid[set_idx] <= 1'b1;
        end
    end

    assign rd_valid = valid[rd_idx];
endmodule

// File: rtl/cache_fill_ctrl.sv
// Requester-side controller for a 16-line direct-mapped cache: hit judgement,
// read-miss refill over a req/ack memory port, write-through with allocate.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W  = cache_pkg::ADDR_W,
    parameter int DATA_W  = cache_pkg::DATA_W,
    parameter int INDEX_W = cache_pkg::INDEX_W,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data_in,
    input  logic [DATA_W-1:0] c_data_out,
    input  logic              c_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t            state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              line_valid;
    logic              hit;

    // A line never written since reset may still match a stale tag in the array.
    assign hit = c_hit & line_valid;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign c_addr     = (state == S_IDLE) ? req_addr : r_addr;
    assign c_we       = ((state == S_LOOKUP) && r_we) || (state == S_FILL);
    assign c_data_in  = (state == S_FILL) ? resp_rdata : r_wdata;
    assign mem_req    = (state == S_MEM_RD) || (state == S_MEM_WR);
    assign mem_we     = (state == S_MEM_WR);
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

    cache_valid_bits #(.INDEX_W(INDEX_W)) u_valid (
        .clk      (clk),
        .reset    (reset),
        .set      (c_we),
        .set_idx  (r_addr[INDEX_W-1:0]),
        .rd_idx   (r_addr[INDEX_W-1:0]),
        .rd_valid (line_valid)
    );

    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            resp_rdata <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) state <= S_LOOKUP;
                S_LOOKUP: begin
                    if (r_we) begin
                        state <= S_MEM_WR;
                    end else if (hit) begin
                        resp_rdata <= c_data_out;
                        hit_cnt    <= sat_inc(hit_cnt);
                        state      <= S_RESP;
                    end else begin
                        miss_cnt <= sat_inc(miss_cnt);
                        state    <= S_MEM_RD;
                    end
                end
                S_MEM_RD: if (mem_ack) begin
                    resp_rdata <= mem_rdata;
                    state      <= S_FILL;
                end
                S_FILL: state <= S_RESP;
                S_MEM_WR: if (mem_ack) begin
                    resp_rdata <= r_wdata;
                    state      <= S_RESP;
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: behavioural cache array and memory around the DUT,
// directed scenarios then randomized traffic against an abstract reference model.
module tb_cache_fill_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [7:0]  req_addr, req_wdata;
    logic        req_ready, resp_valid;
    logic [7:0]  resp_rdata;
    logic        c_we, c_hit;
    logic [7:0]  c_addr, c_data_in, c_data_out;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic [15:0] hit_cnt, miss_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // environment: cache array, backing memory, ack generator
    logic [3:0] ctag [16];
    logic [7:0] cdat [16];
    logic [7:0] mem  [256];
    logic       env_init = 1'b0;
    int         ack_dly = 0;
    int         req_cyc = 0;
    logic       ack_q = 1'b0;
    logic       late_ack = 1'b0;

    // reference model state
    logic [7:0]  m_mem   [256];
    bit          m_valid [16];
    logic [3:0]  m_tag   [16];
    logic [7:0]  m_data  [16];
    logic [15:0] m_hit, m_miss;

    cache_fill_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .c_we(c_we), .c_addr(c_addr), .c_data_in(c_data_in), .c_data_out(c_data_out), .c_hit(c_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    assign c_hit      = (ctag[c_addr[3:0]] == c_addr[7:4]);
    assign c_data_out = cdat[c_addr[3:0]];
    assign mem_ack    = ack_q | late_ack;

    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 16; i++) begin
                ctag[i] <= 4'($urandom);
                cdat[i] <= 8'($urandom);
            end
        end else if (c_we) begin
            ctag[c_addr[3:0]] <= c_addr[7:4];
            cdat[c_addr[3:0]] <= c_data_in;
        end
    end

    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= m_mem[i];
        end else if (mem_req && mem_we && mem_ack) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_req) begin
            req_cyc <= req_cyc + 1;
            ack_q   <= (req_cyc == ack_dly);
        end else begin
            req_cyc <= 0;
            ack_q   <= 1'b0;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hit  = '0;
        m_miss = '0;
    endtask

    // One full transaction: drive request, watch every cycle, compare against the model.
    task automatic run_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata, input int dly);
        logic [3:0] idx;
        bit         exp_hit, done, addr_ok, we_ok;
        logic [7:0] exp_data, got_data;
        int         exp_lat, exp_req, exp_cwe_cyc, lat, n_req, n_cwe, cwe_cyc;
        idx     = addr[3:0];
        exp_hit = !we && m_valid[idx] && (m_tag[idx] == addr[7:4]);
        if (we) begin
            exp_data = wdata; exp_lat = 3 + dly; exp_req = dly + 1; exp_cwe_cyc = 1;
        end else if (exp_hit) begin
            exp_data = m_data[idx]; exp_lat = 2; exp_req = 0; exp_cwe_cyc = 0;
        end else begin
            exp_data = m_mem[addr]; exp_lat = 4 + dly; exp_req = dly + 1; exp_cwe_cyc = 3 + dly;
        end
        ack_dly = dly;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        done = 0; addr_ok = 1; we_ok = 1; lat = 0; n_req = 0; n_cwe = 0; cwe_cyc = 0; got_data = '0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = 8'($urandom);
            req_we    = 1'($urandom);
            if (mem_req) begin
                n_req++;
                if (mem_addr !== addr) addr_ok = 0;
                if (mem_we !== we) we_ok = 0;
                if (we && mem_wdata !== wdata) addr_ok = 0;
            end
            if (c_we) begin
                n_cwe++;
                cwe_cyc = cyc;
            end
            if (resp_valid) begin
                done = 1; lat = cyc; got_data = resp_rdata;
            end
        end
        if (!done) chk("resp_timeout", 0, 1);
        @(negedge clk);
        chk("resp_one_cycle", resp_valid, 0);
        chk("resp_rdata_hold", resp_rdata, exp_data);
        chk("latency", lat, exp_lat);
        chk("resp_rdata", got_data, exp_data);
        chk("mem_req_cycles", n_req, exp_req);
        chk("mem_fields_stable", addr_ok, 1);
        chk("mem_we", we_ok, 1);
        chk("c_we_count", n_cwe, (exp_cwe_cyc != 0) ? 1 : 0);
        chk("c_we_cycle", cwe_cyc, exp_cwe_cyc);
        if (we) begin
            m_valid[idx] = 1; m_tag[idx] = addr[7:4]; m_data[idx] = wdata; m_mem[addr] = wdata;
        end else if (exp_hit) begin
            if (m_hit != 16'hFFFF) m_hit++;
        end else begin
            if (m_miss != 16'hFFFF) m_miss++;
            m_valid[idx] = 1; m_tag[idx] = addr[7:4]; m_data[idx] = m_mem[addr];
        end
        chk("hit_cnt", hit_cnt, m_hit);
        chk("miss_cnt", miss_cnt, m_miss);
    endtask

    initial begin
        bit saw_resp;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
        m_mem[8'h35] = 8'hA7;
        m_mem[8'h45] = 8'h11;
        model_reset();
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        env_init = 1'b1;
        repeat (2) @(negedge clk);
        env_init = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_c_we", c_we, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        reset = 1'b0;

        run_txn(0, 8'h35, 8'h00, 0);
        run_txn(0, 8'h35, 8'h00, 0);
        run_txn(0, 8'h45, 8'h00, 1);
        run_txn(0, 8'h35, 8'h00, 0);
        run_txn(1, 8'h9C, 8'h5E, 3);
        run_txn(0, 8'h9C, 8'h00, 0);

        // reset while a read miss waits for memory, then a stray late ack
        ack_dly = 100;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h77;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_mem_req_before", mem_req, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_req_dropped", mem_req, 0);
        reset = 1'b0;
        late_ack = 1'b1;
        model_reset();
        saw_resp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            late_ack = 1'b0;
            if (resp_valid || mem_req || !req_ready) saw_resp = 1;
        end
        chk("rst_mid_quiet_idle", saw_resp, 0);
        ack_dly = 0;
        run_txn(0, 8'h35, 8'h00, 0);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] a;
            a = {2'b00, 2'($urandom_range(0, 2)), 2'b00, 2'($urandom_range(0, 3))};
            run_txn(($urandom_range(0, 2) == 0), a, 8'($urandom), $urandom_range(0, 3));
        end

        // counter saturation
        run_txn(0, 8'h35, 8'h00, 0);
        @(negedge clk);
        force dut.hit_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.hit_cnt;
        m_hit = 16'hFFFE;
        chk("hit_cnt_preset", hit_cnt, 16'hFFFE);
        repeat (3) run_txn(0, 8'h35, 8'h00, 0);
        chk("hit_cnt_saturated", hit_cnt, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
